// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
package sipo_frame_ctrl_pkg;

    // Bits per frame when the parent does not override WIDTH.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states: IDLE waits for start, SHIFT assembles a frame.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of a counter that must hold the values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Control/data bundle between the frame controller and its user.
// master = the side driving serial bits and handshake; slave = the controller.
interface sipo_frame_ctrl_if
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int CW = cnt_width(WIDTH);

    logic             start;
    logic             sin;
    logic             sin_valid;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;

    modport master (
        output start, sin, sin_valid, out_ready, clr_ovr,
        input  pout, pout_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  start, sin, sin_valid, out_ready, clr_ovr,
        output pout, pout_valid, busy, bit_cnt, overrun
    );

endinterface

// File: rtl/sipo_shift.sv
// Right-shifting serial-in register: new bits enter at the MSB and walk toward
// bit 0, so after WIDTH shifts the first bit sits at q[0] (LSB-first framing).
module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // Per-bit next value; clr wins and may capture the first bit in the same cycle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_top
                assign q_next[gi] = clr ? (en & sin) : (en ? sin : q_reg[gi]);
            end else begin : g_low
                assign q_next[gi] = clr ? 1'b0 : (en ? q_reg[gi+1] : q_reg[gi]);
            end
        end
    endgenerate

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: counts accepted serial bits, hands each completed word to a
// valid/ready output register, and flags words dropped while that register is full.
module sipo_frame_ctrl
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    sipo_frame_ctrl_if.slave  bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] pout_reg, pout_next;
    logic             pout_valid_reg, pout_valid_next;
    logic             overrun_reg, overrun_next;

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word;
    logic             accept;
    logic             complete;
    logic             load_word;
    logic             drop_word;
    logic             shift_lsb_unused;

    // A bit is taken on a start cycle or while shifting; idle strobes are ignored.
    assign accept    = bus.sin_valid & (bus.start | (state_reg == SHIFT));
    assign complete  = (state_reg == SHIFT) & ~bus.start & bus.sin_valid & (bit_cnt_reg == LAST);
    // The finished word is the register's next value, so it can load with zero latency.
    assign word      = {bus.sin, shift_q[WIDTH-1:1]};
    // The LSB is always shifted out by the time the last bit arrives.
    assign shift_lsb_unused = shift_q[0];
    assign load_word = complete & (~pout_valid_reg | bus.out_ready);
    assign drop_word = complete & pout_valid_reg & ~bus.out_ready;

    sipo_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.start),
        .en    (accept),
        .sin   (bus.sin),
        .q     (shift_q)
    );

    // State, counter, output word and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            pout_reg       <= '0;
            pout_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            pout_reg       <= pout_next;
            pout_valid_reg <= pout_valid_next;
            overrun_reg    <= overrun_next;
        end
    end

    // Next-state, bit counting, output handshake and sticky overrun.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        pout_next       = pout_reg;
        pout_valid_next = pout_valid_reg;
        overrun_next    = overrun_reg;

        if (bus.start) begin
            state_next   = SHIFT;
            bit_cnt_next = bus.sin_valid ? CW'(1) : '0;
        end else if ((state_reg == SHIFT) && bus.sin_valid) begin
            if (bit_cnt_reg == LAST) begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end else begin
                bit_cnt_next = bit_cnt_reg + CW'(1);
            end
        end

        if (load_word) begin
            pout_next       = word;
            pout_valid_next = 1'b1;
        end else if (pout_valid_reg && bus.out_ready) begin
            pout_valid_next = 1'b0;
        end

        if (drop_word) begin
            overrun_next = 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_next = 1'b0;
        end
    end

    assign bus.pout       = pout_reg;
    assign bus.pout_valid = pout_valid_reg;
    assign bus.busy       = (state_reg == SHIFT);
    assign bus.bit_cnt    = bit_cnt_reg;
    assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl (WIDTH=4): a per-cycle vector table, hand-written
// multi-cycle sequences, and a scoreboard of words expected on the output handshake.
module tb_sipo_frame_ctrl;
    import sipo_frame_ctrl_pkg::*;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    typedef struct packed {
        logic [4:0] in;      // {start, sin, sin_valid, out_ready, clr_ovr}
        logic       busy;
        logic [2:0] cnt;
        logic       pv;
        logic       ovr;
        logic [3:0] pout;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic [4:0] in, input logic busy, input logic [2:0] cnt,
                                input logic pv, input logic ovr, input logic [3:0] pout);
        vec_t v;
        v.in = in; v.busy = busy; v.cnt = cnt; v.pv = pv; v.ovr = ovr; v.pout = pout;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic v, input logic r, input logic c);
        bus.start     = s;
        bus.sin       = d;
        bus.sin_valid = v;
        bus.out_ready = r;
        bus.clr_ovr   = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic busy, input logic [2:0] cnt,
                             input logic pv, input logic ovr, input logic [3:0] pout);
        check({tag, "_busy"}, bus.busy, busy);
        check({tag, "_cnt"},  bus.bit_cnt, cnt);
        check({tag, "_pv"},   bus.pout_valid, pv);
        check({tag, "_ovr"},  bus.overrun, ovr);
        check({tag, "_pout"}, bus.pout, pout);
    endtask

    // Start cycle, then W bits (w[0] first) with optional random idle gaps.
    task automatic run_frame(input logic [W-1:0] w, input int gap_max, input logic rdy,
                             input logic rdy_last, input logic clr_last);
        int gaps;
        drive(1'b1, 1'b0, 1'b0, rdy, 1'b0);
        tick();
        check("frame_start_busy", bus.busy, 1);
        check("frame_start_cnt", bus.bit_cnt, 0);
        for (int i = 0; i < W; i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gaps; g++) begin
                drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
                tick();
                check("gap_cnt_hold", bus.bit_cnt, i);
                check("gap_busy_hold", bus.busy, 1);
            end
            drive(1'b0, w[i], 1'b1, (i == W - 1) ? rdy_last : rdy, (i == W - 1) ? clr_last : 1'b0);
            tick();
            if (i < W - 1) check("bit_cnt_step", bus.bit_cnt, i + 1);
        end
        drive(1'b0, 1'b0, 1'b0, rdy_last, 1'b0);
    endtask

    // Scoreboard: a word transfers on every edge where pout_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && bus.pout_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got word %b expected no word", bus.pout);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("sb_word", bus.pout, e);
                $display("txn word=%b expected=%b", bus.pout, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d checks done", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // start sin sv rdy clr      busy cnt pv ovr pout
        tbl[0]  = mk(5'b10010, 1, 0, 0, 0, 4'b0000);
        tbl[1]  = mk(5'b01110, 1, 1, 0, 0, 4'b0000);
        tbl[2]  = mk(5'b01110, 1, 2, 0, 0, 4'b0000);
        tbl[3]  = mk(5'b00110, 1, 3, 0, 0, 4'b0000);
        tbl[4]  = mk(5'b01110, 0, 0, 1, 0, 4'b1011);
        tbl[5]  = mk(5'b00010, 0, 0, 0, 0, 4'b1011);
        tbl[6]  = mk(5'b10010, 1, 0, 0, 0, 4'b1011);
        tbl[7]  = mk(5'b01110, 1, 1, 0, 0, 4'b1011);
        tbl[8]  = mk(5'b01110, 1, 2, 0, 0, 4'b1011);
        tbl[9]  = mk(5'b10110, 1, 1, 0, 0, 4'b1011);
        tbl[10] = mk(5'b00110, 1, 2, 0, 0, 4'b1011);
        tbl[11] = mk(5'b01110, 1, 3, 0, 0, 4'b1011);
        tbl[12] = mk(5'b00110, 0, 0, 1, 0, 4'b0100);
        tbl[13] = mk(5'b00010, 0, 0, 0, 0, 4'b0100);
        tbl[14] = mk(5'b01110, 0, 0, 0, 0, 4'b0100);
        tbl[15] = mk(5'b10010, 1, 0, 0, 0, 4'b0100);
        tbl[16] = mk(5'b01110, 1, 1, 0, 0, 4'b0100);
        tbl[17] = mk(5'b01110, 1, 2, 0, 0, 4'b0100);
        tbl[18] = mk(5'b01110, 1, 3, 0, 0, 4'b0100);
        tbl[19] = mk(5'b11110, 1, 1, 0, 0, 4'b0100);
        tbl[20] = mk(5'b00110, 1, 2, 0, 0, 4'b0100);
        tbl[21] = mk(5'b00110, 1, 3, 0, 0, 4'b0100);
        tbl[22] = mk(5'b01110, 0, 0, 1, 0, 4'b1001);
        tbl[23] = mk(5'b00010, 0, 0, 0, 0, 4'b1001);

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 4'b0000);
        rst_n = 1'b1;
        tick();
        check_all("post_reset", 0, 0, 0, 0, 4'b0000);

        // Vector table: basic frame, restart mid-frame, idle strobes, restart on final bit
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1001);
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            tick();
            check_all($sformatf("row%0d", i), tbl[i].busy, tbl[i].cnt, tbl[i].pv, tbl[i].ovr, tbl[i].pout);
        end

        // Output held full: second word dropped, overrun sticky, set beats clear
        exp_q.push_back(4'b0001);
        run_frame(4'b0001, 0, 1'b0, 1'b0, 1'b0);
        check_all("ovr_first", 0, 0, 1, 0, 4'b0001);
        run_frame(4'b1110, 0, 1'b0, 1'b0, 1'b0);
        check_all("ovr_drop", 0, 0, 1, 1, 4'b0001);
        tick();
        check("ovr_sticky", bus.overrun, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("ovr_clear", bus.overrun, 0);
        run_frame(4'b0101, 0, 1'b0, 1'b0, 1'b1);
        check_all("ovr_set_wins", 0, 0, 1, 1, 4'b0001);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("ovr_clear2", bus.overrun, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("ovr_drain_pv", bus.pout_valid, 0);

        // Gapped strobes
        exp_q.push_back(4'b1010);
        run_frame(4'b1010, 7, 1'b1, 1'b1, 1'b0);
        check_all("gap_done", 0, 0, 1, 0, 4'b1010);
        tick();
        check("gap_drain_pv", bus.pout_valid, 0);

        // Completion in the same cycle as a transfer: replace, valid held
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b1100);
        run_frame(4'b0011, 0, 1'b0, 1'b0, 1'b0);
        check_all("repl_first", 0, 0, 1, 0, 4'b0011);
        run_frame(4'b1100, 0, 1'b0, 1'b1, 1'b0);
        check_all("repl_second", 0, 0, 1, 0, 4'b1100);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("repl_drain_pv", bus.pout_valid, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame with nonzero pout and overrun set
        exp_q.push_back(4'b0111);
        run_frame(4'b0111, 0, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1111, 0, 1'b0, 1'b0, 1'b0);
        check("rst_pre_ovr", bus.overrun, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check_all("rst_pre", 1, 2, 0, 1, 4'b0111);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 0, 0, 0, 0, 4'b0000);
        tick();
        check_all("rst_held", 0, 0, 0, 0, 4'b0000);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_start_cnt", bus.bit_cnt, 0);
            check("rst_no_start_busy", bus.busy, 0);
        end
        exp_q.push_back(4'b0110);
        run_frame(4'b0110, 0, 1'b1, 1'b1, 1'b0);
        check_all("rst_after", 0, 0, 1, 0, 4'b0110);
        tick();
        check("rst_after_drain", bus.pout_valid, 0);

        check("sb_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bits per frame (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin a new frame; also restarts a frame in progress.
REQ-005 SHALL have port sin  input  1  serial data bit, sampled only when sin_valid=1.
REQ-006 SHALL have port sin_valid  input  1  bit strobe; qualifies sin for one clk cycle.
REQ-007 SHALL have port out_ready  input  1  downstream accepts pout this cycle.
REQ-008 SHALL have port clr_ovr  input  1  clears the sticky overrun flag.
REQ-009 SHALL have port pout  output  WIDTH  completed parallel word.
REQ-010 SHALL have port pout_valid  output  1  pout holds an unconsumed word.
REQ-011 SHALL have port busy  output  1  a frame is being assembled (state SHIFT).
REQ-012 SHALL have port bit_cnt  output  $clog2(WIDTH+1)  bits accepted in the current frame.
REQ-013 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT; busy=1 exactly in SHIFT.
REQ-015 In IDLE, when start=1: SHALL clear the shift register, set bit_cnt=0 and enter SHIFT; sin_valid=1 in the same cycle SHALL capture sin as frame bit 0 (bit_cnt=1).
REQ-016 In IDLE, when start=0: sin_valid SHALL be ignored.
REQ-017 In SHIFT, each sin_valid=1 SHALL shift sin into shift-register bit WIDTH-1, move all other bits one position toward bit 0, and increment bit_cnt.
REQ-018 Serial order SHALL be LSB-first: after the frame completes, the first accepted bit is at pout[0] and the last at pout[WIDTH-1].
REQ-019 In SHIFT, start=1 SHALL take priority over all other events: it discards the partial frame, restarts per REQ-015, and stays in SHIFT. This includes the final-bit cycle, where no word is emitted.
REQ-020 Frame completion SHALL occur on the edge that samples bit WIDTH-1 (bit_cnt=WIDTH-1 and sin_valid=1, start=0). On that edge the FSM SHALL return to IDLE and bit_cnt SHALL return to 0.
REQ-021 On completion, if pout_valid=0 or out_ready=1, the assembled word SHALL load into pout and pout_valid=1 on that same edge, i.e. zero added latency.
REQ-022 On completion, if pout_valid=1 and out_ready=0, the new word SHALL be dropped, pout SHALL be unchanged, and overrun SHALL set to 1.
REQ-023 Handshake: the word transfers on any edge with pout_valid=1 and out_ready=1. If no new word loads on that edge, pout_valid SHALL clear. pout SHALL be stable while pout_valid=1.
REQ-024 overrun SHALL remain 1 until clr_ovr=1. If a set event (REQ-022) and clr_ovr occur in the same cycle, set SHALL win.
REQ-025 sin_valid gaps of any length in SHIFT SHALL hold state. The block SHALL have no timeout.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, shift register=0, bit_cnt=0, pout=0, pout_valid=0, busy=0 and overrun=0, regardless of clk.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame. After release, no bit SHALL be accepted until the next start.

Structure
REQ-028 Package sipo_frame_ctrl_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-029 The shift datapath SHALL be a sub-module sipo_shift (ports clk, rst_n, clr, en, sin, q[WIDTH-1:0]). The controller SHALL own only the FSM, bit counter, output register and flags.

Verification (WIDTH=4)
REQ-030 Scenario 1: start plus bits 1,1,0,1 with out_ready=1 -> pout=4'b1011 and pout_valid=1 on the edge sampling the 4th bit; busy falls on the same edge.
REQ-031 Scenario 2: out_ready=0, frame 1,0,0,0 then frame 0,1,1,1 -> pout stays 4'b0001, overrun=1; clr_ovr pulse -> overrun=0.
REQ-032 Scenario 3: start, bits 1,1, start again, bits 0,0,1,0 -> pout=4'b0100; the first partial frame is lost and no overrun is flagged.
REQ-033 Scenario 4: rst_n pulled low between clk edges after 2 bits -> all outputs 0 immediately; sin_valid pulses without start after release -> bit_cnt stays 0.
REQ-034 Scenario 5: pout_valid=1 and out_ready=1 in the same cycle as a new completion -> new word replaces old with pout_valid held at 1 and overrun=0.
REQ-035 Scenario 6: sin_valid gapped by 0..7 idle cycles between bits of frame 0,1,0,1 -> pout=4'b1010 and bit_cnt increments exactly once per strobe.
